clk_switch_ctrl: RTL

CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

---
 rtl/clk_switch_ctrl.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: sequences a glitch-safe move between the reference clock
// and a PLL clock. A configuration request parks the mux on the reference,
// reprograms the PLL dividers, waits for a settled lock, switches to the PLL
// and finally pulses a soft reset. Bypass requests skip the PLL steps.
//
// Optional feature macro: CLK_SWITCH_LOCK_MON_EN
//   defined   - two consecutive low pll_lock_i cycles while in RUN drop the
//               mux back to the reference clock, set err_o and return to IDLE
//   undefined - pll_lock_i is only looked at while waiting for lock
module clk_switch_ctrl #(
  parameter int SWITCH_GAP    = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 1023,
  parameter int RST_CYCLES    = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic        cfg_bypass_i,
  input  logic [5:0]  cfg_ref_div_i,
  input  logic [11:0] cfg_fb_div_i,
  input  logic [2:0]  cfg_post_div1_i,
  input  logic [2:0]  cfg_post_div2_i,
  output logic [5:0]  pll_ref_div_o,
  output logic [11:0] pll_feedback_div_o,
  output logic [2:0]  pll_post_div1_o,
  output logic [2:0]  pll_post_div2_o,
  input  logic        pll_lock_i,
  output logic        clk_sel_o,
  output logic        soft_reset_en_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  // One counter width covers every programmable duration.
  localparam int MAX_AB  = (SWITCH_GAP > SETTLE_CYCLES) ? SWITCH_GAP : SETTLE_CYCLES;
  localparam int MAX_CD  = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
  localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    TO_REF    = 3'd2,
    PROG      = 3'd3,
    WAIT_LOCK = 3'd4,
    TO_PLL    = 3'd5,
    RST       = 3'd6
  } state_t;

  // Counters stop at all-ones instead of wrapping back to zero.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == {CW{1'b1}}) begin
      return v;
    end else begin
      return v + CW'(1);
    end
  endfunction

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;        // dwell counter for TO_REF / TO_PLL / RST
  logic [CW-1:0] settle, settle_next;  // consecutive locked cycles
  logic [CW-1:0] tmo, tmo_next;        // cycles spent in WAIT_LOCK
  logic          sel_next;
  logic          err_next;
  logic          done_next;
  logic          accept;

  logic          lat_bypass;
  logic [5:0]    lat_ref;
  logic [11:0]   lat_fb;
  logic [2:0]    lat_p1;
  logic [2:0]    lat_p2;

`ifdef CLK_SWITCH_LOCK_MON_EN
  logic          lock_low, lock_low_next;  // previous RUN cycle saw lock low
`endif

  assign accept = cfg_valid_i & cfg_ready_o;

  // Next-state, counter and flag computation for the switch sequence.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    settle_next = settle;
    tmo_next    = tmo;
    sel_next    = clk_sel_o;
    err_next    = err_o;
    done_next   = 1'b0;
`ifdef CLK_SWITCH_LOCK_MON_EN
    lock_low_next = 1'b0;
`endif
    case (state)
      IDLE, RUN: begin
        if (accept) begin
          state_next = TO_REF;
          cnt_next   = '0;
          err_next   = 1'b0;
          sel_next   = 1'b0;
        end else begin
`ifdef CLK_SWITCH_LOCK_MON_EN
          if ((state == RUN) && !pll_lock_i) begin
            if (lock_low) begin
              state_next = IDLE;
              sel_next   = 1'b0;
              err_next   = 1'b1;
            end else begin
              lock_low_next = 1'b1;
            end
          end else begin
            lock_low_next = 1'b0;
          end
`else
          state_next = state;
`endif
        end
      end
      TO_REF: begin
        if (cnt >= CW'(SWITCH_GAP - 1)) begin
          cnt_next   = '0;
          state_next = lat_bypass ? RST : PROG;
        end else begin
          cnt_next = sat_inc(cnt);
        end
      end
      PROG: begin
        state_next  = WAIT_LOCK;
        settle_next = '0;
        tmo_next    = '0;
      end
      WAIT_LOCK: begin
        settle_next = pll_lock_i ? sat_inc(settle) : '0;
        tmo_next    = sat_inc(tmo);
        // A settle reached on the same cycle as the timeout takes priority.
        if (settle_next >= CW'(SETTLE_CYCLES)) begin
          state_next = TO_PLL;
          sel_next   = 1'b1;
          cnt_next   = '0;
        end else if (tmo_next >= CW'(LOCK_TIMEOUT)) begin
          state_next = IDLE;
          sel_next   = 1'b0;
          err_next   = 1'b1;
          done_next  = 1'b1;
        end else begin
          state_next = WAIT_LOCK;
        end
      end
      TO_PLL: begin
        if (cnt >= CW'(SWITCH_GAP - 1)) begin
          cnt_next   = '0;
          state_next = RST;
        end else begin
          cnt_next = sat_inc(cnt);
        end
      end
      RST: begin
        if (cnt >= CW'(RST_CYCLES - 1)) begin
          cnt_next   = '0;
          state_next = lat_bypass ? IDLE : RUN;
          done_next  = 1'b1;
        end else begin
          cnt_next = sat_inc(cnt);
        end
      end
      default: begin
        state_next = IDLE;
        sel_next   = 1'b0;
        cnt_next   = '0;
      end
    endcase
  end

  // Control state register and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      cnt             <= '0;
      settle          <= '0;
      tmo             <= '0;
      clk_sel_o       <= 1'b0;
      err_o           <= 1'b0;
      done_o          <= 1'b0;
      busy_o          <= 1'b0;
      soft_reset_en_o <= 1'b0;
      cfg_ready_o     <= 1'b1;
`ifdef CLK_SWITCH_LOCK_MON_EN
      lock_low        <= 1'b0;
`endif
    end else begin
      state           <= state_next;
      cnt             <= cnt_next;
      settle          <= settle_next;
      tmo             <= tmo_next;
      clk_sel_o       <= sel_next;
      err_o           <= err_next;
      done_o          <= done_next;
      busy_o          <= !((state_next == IDLE) || (state_next == RUN));
      cfg_ready_o     <= (state_next == IDLE) || (state_next == RUN);
      soft_reset_en_o <= (state_next == RST);
`ifdef CLK_SWITCH_LOCK_MON_EN
      lock_low        <= lock_low_next;
`endif
    end
  end

  // Request capture on handshake and divider programming on entry to PROG.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lat_bypass         <= 1'b0;
      lat_ref            <= 6'd1;
      lat_fb             <= 12'd1;
      lat_p1             <= 3'd1;
      lat_p2             <= 3'd1;
      pll_ref_div_o      <= 6'd1;
      pll_feedback_div_o <= 12'd1;
      pll_post_div1_o    <= 3'd1;
      pll_post_div2_o    <= 3'd1;
    end else begin
      if (accept) begin
        lat_bypass <= cfg_bypass_i;
        lat_ref    <= cfg_ref_div_i;
        lat_fb     <= cfg_fb_div_i;
        lat_p1     <= cfg_post_div1_i;
        lat_p2     <= cfg_post_div2_i;
      end
      if (state_next == PROG) begin
        pll_ref_div_o      <= lat_ref;
        pll_feedback_div_o <= lat_fb;
        pll_post_div1_o    <= lat_p1;
        pll_post_div2_o    <= lat_p2;
      end
    end
  end

endmodule
